// File: rtl/w_fifo_pkg.sv
// w_fifo_pkg: shared pointer-width helper and default beat layout for the W-channel FIFO
package w_fifo_pkg;
  function automatic int PTR_W(input int depth);
    return $clog2(depth) + 1;
  endfunction
  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  strb;
    logic        last;
  } w_beat_t;
endpackage

// File: rtl/w_fifo_mem.sv
// w_fifo_mem: simple dual-port register array, synchronous write, asynchronous read
module w_fifo_mem #(
  parameter int W     = 37,
  parameter int DEPTH = 8,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);
  logic [W-1:0] mem [DEPTH];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/w_burst_fifo.sv
// w_burst_fifo: W-channel beat FIFO with optional store-and-forward release and burst accounting
module w_burst_fifo
  import w_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int STRB_WIDTH = DATA_WIDTH / 8,
  parameter int DEPTH      = 8,
  parameter int AF_LEVEL   = DEPTH - 2,
  parameter int STORE_FWD  = 0,
  localparam int PW        = PTR_W(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] WDATA,
  input  logic [STRB_WIDTH-1:0] WSTRB,
  input  logic                  WLAST,
  input  logic                  push,
  input  logic                  pop,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic [PW-1:0]         level,
  output logic [PW-1:0]         burst_count,
  output logic                  overflow,
  output logic [DATA_WIDTH-1:0] front_WDATA,
  output logic [STRB_WIDTH-1:0] front_WSTRB,
  output logic                  front_WLAST
);
  localparam int AW = PW - 1;
  localparam int BW = DATA_WIDTH + STRB_WIDTH + 1;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [BW-1:0] rd_beat;
  logic          do_push, do_pop;
  assign full = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  // store-and-forward holds beats back until a whole burst is in, unless full would deadlock
  assign empty = (wr_ptr == rd_ptr) || (STORE_FWD != 0 && burst_count == '0 && !full);
  assign almost_full = level >= PW'(AF_LEVEL);
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  assign {front_WLAST, front_WSTRB, front_WDATA} = empty ? '0 : rd_beat;
  w_fifo_mem #(.W(BW), .DEPTH(DEPTH)) u_mem (
    .clk   (clk),
    .we    (do_push),
    .waddr (wr_ptr[AW-1:0]),
    .wdata ({WLAST, WSTRB, WDATA}),
    .raddr (rd_ptr[AW-1:0]),
    .rdata (rd_beat)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      level       <= '0;
      burst_count <= '0;
      overflow    <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop) rd_ptr <= rd_ptr + PW'(1);
      level       <= level + PW'(do_push) - PW'(do_pop);
      burst_count <= burst_count + PW'(do_push && WLAST) - PW'(do_pop && front_WLAST);
      if (push && full) overflow <= 1'b1;
    end
  end
endmodule

// File: doc/w_burst_fifo.md
# w_burst_fifo

Single-clock, parametrised write-data (W channel) FIFO for the crossbar's slave-side ports. It buffers WDATA/WSTRB/WLAST beats with configurable width and depth. It adds a store-and-forward mode that withholds beats until a complete burst (WLAST) is stored. It also reports occupancy, the number of complete bursts, an almost-full threshold and a sticky overflow flag, so same-clock-domain ports can be buffered without an asynchronous FIFO.

## Interface
- DATA_WIDTH, 32, WDATA width in bits; multiple of 8
- STRB_WIDTH, DATA_WIDTH/8, WSTRB width
- DEPTH, 8, entries; power of two, ≥ 2
- AF_LEVEL, DEPTH-2, level at or above which almost_full asserts; 1 ≤ AF_LEVEL ≤ DEPTH
- STORE_FWD, 0, 0 = cut-through, 1 = store-and-forward
- clk  input  1  single clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- WDATA  input  DATA_WIDTH  beat data
- WSTRB  input  STRB_WIDTH  beat strobes
- WLAST  input  1  last beat of burst
- push  input  1  write request
- pop  input  1  read request
- full  output  1  no free entry
- empty  output  1  no beat presentable
- almost_full  output  1  level ≥ AF_LEVEL
- level  output  $clog2(DEPTH)+1  stored beats, 0..DEPTH
- burst_count  output  $clog2(DEPTH)+1  stored beats with WLAST=1
- overflow  output  1  sticky: push attempted while full
- front_WDATA / front_WSTRB / front_WLAST  output  DATA_WIDTH / STRB_WIDTH / 1  head beat; all zero while empty

## Operation
- Accepted push = push & !full: writes the beat at wr_ptr and advances wr_ptr.
- Accepted pop = pop & !empty: advances rd_ptr.
- Pointers are $clog2(DEPTH)+1 bits. The MSB is the wrap bit; full/empty raw comparisons use it.
- level updates: +1 on push only, −1 on pop only, unchanged on both or neither.
- burst_count updates: +1 on an accepted push with WLAST=1, −1 on an accepted pop with front_WLAST=1, unchanged when both occur.
- full = (level == DEPTH). It is evaluated on registered state, so a same-cycle pop does not admit a push when full.
- Cut-through: empty = (level == 0).
- Store-and-forward: empty = (level == 0) | ((burst_count == 0) & !full).
  - When full with no complete burst stored, beats are released to avoid deadlock.
- Push while full: beat discarded, pointers unchanged, overflow set. overflow clears only on rst.
- Pop while empty: ignored; no state change.
- Push and pop while empty (level 0): the push is accepted and the pop ignored. No bypass path exists.
- front_* are first-word-fall-through: combinational from the memory at rd_ptr, gated to zero when empty.
- Reset: both pointers 0, level 0, burst_count 0, overflow 0, full 0, empty 1, almost_full 0, front_* 0. Memory contents are not reset. rst asserted mid-burst discards all stored beats.

## Timing
- Push at edge N: level, full and almost_full reflect it after edge N. The beat is visible on front_* in cycle N+1.
  - Cut-through: when level was 0, empty deasserts in cycle N+1.
  - Store-and-forward: empty deasserts in the cycle after the WLAST beat is accepted, or after the FIFO becomes full.
- Pop at edge N: the next beat is on front_* in cycle N+1.
- All status outputs are functions of registered state only. No output depends combinationally on push or pop.
- Throughput: one push and one pop per cycle sustained.

## Structure
- Package w_fifo_pkg:
  - parametrised-width helper function clog2-based PTR_W(DEPTH)
  - w_beat_t struct {data, strb, last} for the default 32-bit configuration
- Sub-module w_fifo_mem: simple dual-port register array, DEPTH × (DATA_WIDTH+STRB_WIDTH+1).
  - Synchronous write, asynchronous read, no reset.
- The top level holds pointers, counters, flags and mode logic.

## Test plan
- Reset: assert rst 2 cycles → empty=1, full=0, level=0, burst_count=0, overflow=0, front_*=0.
- Cut-through, DEPTH=8: push 8 beats with data 0x10..0x17 → full=1 and level=8. A 9th push sets overflow=1 and leaves level=8. Pop 8 → data 0x10..0x17 in order; empty=1 after the last pop.
- Store-and-forward: push a 4-beat burst, WLAST only on beat 4 → empty stays 1 through beat 3 and clears in the cycle after beat 4. burst_count=1.
- Store-and-forward deadlock: push 8 beats with no WLAST → empty=0 once full=1. Popping one beat re-asserts empty.
- Simultaneous push+pop at level 5, pushed beat has WLAST, popped head has WLAST → level stays 5, burst_count unchanged. At level 0 the same stimulus → level=1, head = pushed beat.
- Wrap-around: 20 interleaved push/pop cycles with random gaps, AF_LEVEL=6 → data order preserved across pointer wrap. almost_full tracks level ≥ 6 exactly. rst mid-stream restores the reset values.
